// File: rtl/debounce_ctrl.sv
// Multi-channel switch debouncer: internal sample-tick prescaler plus one
// evaluation engine shared round-robin across all channels.
module debounce_ctrl #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 5000,
  parameter int N_TICKS  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] db_rise,
  output logic [N_CH-1:0] db_fall,
  output logic            tick,
  output logic            busy
);

  localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(N_TICKS + 1);
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [PCNT_W-1:0]            pcnt_q, pcnt_d;
  logic                         tick_q, tick_d;
  logic [N_CH-1:0]              sync1_q, sync1_d;
  logic [N_CH-1:0]              sw_s_q, sw_s_d;
  logic [N_CH-1:0]              db_q, db_d;
  logic [N_CH-1:0]              rise_q, rise_d;
  logic [N_CH-1:0]              fall_q, fall_d;
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw;
    sw_s_d  = sync1_q;
    pcnt_d  = '0;
    tick_d  = 1'b0;
    if (en) begin
      if (pcnt_q == PCNT_W'(TICK_DIV - 1)) begin
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
    end
  end

  // Scheduler and shared evaluation engine: one channel per SCAN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = '0;
    fall_d  = '0;
    case (state_q)
      IDLE: begin
        if (tick_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        for (int i = 0; i < N_CH; i++) begin
          if (idx_q == IDX_W'(i)) begin
            if (sw_s_q[i] == db_q[i]) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(N_TICKS - 1)) begin
              db_d[i]   = sw_s_q[i];
              cnt_d[i]  = '0;
              rise_d[i] = sw_s_q[i];
              fall_d[i] = ~sw_s_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        if (idx_q == IDX_W'(N_CH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sw_s_q  <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      sync1_q <= sync1_d;
      sw_s_q  <= sw_s_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db      = db_q;
  assign db_rise = rise_q;
  assign db_fall = fall_q;
  assign tick    = tick_q;
  assign busy    = (state_q == SCAN);

endmodule
